// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register readback path.
package regfile_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/rdr_hold_reg.sv
// Enable-loaded capture register holding one tagged word {data, addr}.
module rdr_hold_reg #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] hold_q;
    logic [W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (load) begin
            hold_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign q = hold_q;

endmodule

// File: rtl/regfile_reader.sv
// Walks register addresses 0..NREGS-1 through a synchronous read port and
// streams each word, tagged with its address, over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | rd_en asserted for addr_cnt
// WAIT    | bank data arriving; captured into the hold register
// PRESENT | word offered on out_*, held until accepted
// DONE    | one-cycle done pulse
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_cnt_d = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                out_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_cnt_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        // Abort overrides everything, including an acceptance in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            addr_cnt_d  = '0;
            done_d      = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    rdr_hold_reg #(
        .W (DATA_W + ADDR_W)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_q == ST_WAIT),
        .d       ({rd_data, addr_cnt_q}),
        .q       ({out_data, out_addr})
    );

    assign busy      = (state_q != ST_IDLE);
    assign rd_en     = (state_q == ST_READ);
    assign rd_addr   = (state_q == ST_READ) ? addr_cnt_q : '0;
    assign done      = done_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: directed corner sequences plus a table of
// randomized scans checked against an ordered {addr, bank[addr]} model.
module tb_regfile_reader;

    localparam int DW = 10;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n, start, abort, out_ready;
    logic          busy, done, rd_en, out_valid;
    logic [AW-1:0] rd_addr, out_addr;
    logic [DW-1:0] rd_data, out_data;

    regfile_reader #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register bank with one-cycle read latency; tog_en lets a test scribble on rd_data.
    logic [DW-1:0] bank [NR];
    logic [DW-1:0] bank_q = '0;
    logic          tog_en = 1'b0;
    logic [DW-1:0] tog_val = '0;
    always @(posedge clk) if (rd_en) bank_q <= bank[rd_addr];
    assign rd_data = tog_en ? tog_val : bank_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: accepted words, done pulses, first-event cycles, hold stability.
    logic [AW+DW-1:0] got_q[$];
    int               done_cnt, done_cyc, c0, rden_first, valid_first;
    logic             hold_prev = 1'b0;
    logic [AW+DW-1:0] prev_word;

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_word", {19'b0, out_addr, out_data}, {19'b0, prev_word});
            end
            if (out_valid && out_ready && !abort) got_q.push_back({out_addr, out_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc - c0 + 1;
            end
            if (rd_en && rden_first < 0) rden_first = cyc - c0 + 1;
            if (out_valid && valid_first < 0) valid_first = cyc - c0 + 1;
            hold_prev = out_valid && !out_ready && !abort;
            prev_word = {out_addr, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        rden_first  = -1;
        valid_first = -1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pct, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            out_ready = ($urandom_range(0, 99) < pct);
            tick();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic wait_word(input int a);
        int n = 0;
        while (!(out_valid && out_addr == AW'(a)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("word_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_words(input string nm);
        chk({nm, "_count"}, got_q.size(), NR);
        for (int i = 0; i < NR; i++) begin
            if (i < got_q.size())
                chk({nm, "_word"}, {19'b0, got_q[i]}, {19'b0, i[AW-1:0], bank[i]});
        end
    endtask

    task automatic check_idle_zero(input string nm);
        chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
        chk({nm, "_done"}, {31'b0, done}, 32'd0);
        chk({nm, "_rd_en"}, {31'b0, rd_en}, 32'd0);
        chk({nm, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({nm, "_rd_addr"}, {29'b0, rd_addr}, 32'd0);
        chk({nm, "_data"}, {22'b0, out_data}, 32'd0);
        chk({nm, "_addr"}, {29'b0, out_addr}, 32'd0);
    endtask

    typedef struct {
        int pct;
        int kind;
        int exp_words;
        int exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{pct: 100, kind: 0, exp_words: NR, exp_done: 1};
        vecs[1] = '{pct: 50,  kind: 0, exp_words: NR, exp_done: 1};
        vecs[2] = '{pct: 20,  kind: 1, exp_words: NR, exp_done: 1};
        vecs[3] = '{pct: 70,  kind: 2, exp_words: NR, exp_done: 1};
        vecs[4] = '{pct: 35,  kind: 3, exp_words: NR, exp_done: 1};
        vecs[5] = '{pct: 90,  kind: 0, exp_words: NR, exp_done: 1};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NR; i++) bank[i] = DW'(25 * (i + 1));
        clear_mon();
        tick(); tick();
        check_idle_zero("reset");
        reset_n = 1'b1;
        tick();

        // Full scan with timing.
        clear_mon();
        out_ready = 1'b1;
        do_start();
        chk("c1_rd_en", {31'b0, rd_en}, 32'd1);
        chk("c1_rd_addr", {29'b0, rd_addr}, 32'd0);
        wait_done(100, 100);
        chk("rd_en_cycle", rden_first, 32'd1);
        chk("valid_cycle", valid_first, 32'd3);
        chk("done_cycle", done_cyc, 32'd25);
        chk("done_count", done_cnt, 32'd1);
        check_words("full");

        // Backpressure on word 3.
        clear_mon();
        out_ready = 1'b1;
        do_start();
        wait_word(3);
        out_ready = 1'b0;
        repeat (4) begin
            tick();
            chk("bp_data", {22'b0, out_data}, 32'd100);
            chk("bp_addr", {29'b0, out_addr}, 32'd3);
            chk("bp_rd_en", {31'b0, rd_en}, 32'd0);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
        end
        wait_done(100, 100);
        check_words("bp");
        chk("bp_done", done_cnt, 32'd1);

        // start pulsed in cycles 5 and 12 of a running scan.
        clear_mon();
        out_ready = 1'b1;
        do_start();
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(100, 100);
        repeat (10) tick();
        check_words("restart");
        chk("restart_done", done_cnt, 32'd1);
        chk("restart_busy", {31'b0, busy}, 32'd0);

        // Abort while PRESENT with out_ready high.
        clear_mon();
        out_ready = 1'b1;
        do_start();
        wait_word(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        repeat (10) tick();
        chk("abort_no_done", done_cnt, 32'd0);
        chk("abort_words", got_q.size(), 32'd2);
        clear_mon();
        do_start();
        chk("abort_restart_addr", {29'b0, rd_addr}, 32'd0);
        wait_done(100, 100);
        check_words("after_abort");

        // Max value at the last address with rd_data noise during PRESENT.
        bank[7] = 10'h3FF;
        clear_mon();
        out_ready = 1'b1;
        do_start();
        wait_word(7);
        out_ready = 1'b0;
        tog_en = 1'b1;
        repeat (4) begin
            tog_val = DW'($urandom);
            tick();
            chk("max_data", {22'b0, out_data}, 32'h3FF);
        end
        tog_en = 1'b0;
        wait_done(100, 50);
        check_words("max");

        // Reset mid-scan in PRESENT of word 2.
        clear_mon();
        out_ready = 1'b1;
        do_start();
        wait_word(2);
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_idle_zero("midrst");
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (30) tick();
        chk("midrst_no_done", done_cnt, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);

        // Randomized table-driven scans.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NR; i++) begin
                case (vecs[v].kind)
                    1:       bank[i] = 10'h3FF;
                    2:       bank[i] = 10'h000;
                    3:       bank[i] = (i % 2 == 0) ? 10'h2AA : 10'h155;
                    default: bank[i] = DW'($urandom);
                endcase
            end
            clear_mon();
            do_start();
            wait_done(vecs[v].pct, 2000);
            chk("tbl_words", got_q.size(), vecs[v].exp_words);
            chk("tbl_done", done_cnt, vecs[v].exp_done);
            check_words("tbl");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
